// File: rtl/ram_port_arbiter.sv
// Two-port arbiter/sequencer in front of the word-wide data RAM: grants one access at a time,
// drives nRD/nWR for exactly one cycle, captures read data and returns a one-cycle Ack.
module ram_port_arbiter #(
   parameter int MEM_BYTES  = 61,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        Req0,
   input  logic        Req1,
   input  logic        We0,
   input  logic        We1,
   input  logic [31:0] Addr0,
   input  logic [31:0] Addr1,
   input  logic [31:0] WData0,
   input  logic [31:0] WData1,
   output logic        Ack0,
   output logic        Ack1,
   output logic [31:0] RData,
   output logic        Err,
   output logic [31:0] Address,
   output logic [31:0] WriteData,
   output logic        nRD,
   output logic        nWR,
   input  logic [31:0] DataOut
);

   // state  | meaning
   // IDLE   | waiting for a request; arbitration and legality check happen here
   // ACCESS | RAM strobe low for this one cycle; read data captured at its closing edge
   // RESP   | transaction done; Ack of the winner is raised on leaving this state
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES - 1);

   state_t      state_q, state_d;
   logic        gnt_q, gnt_d;
   logic        we_q, we_d;
   logic        last_grant_q, last_grant_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        err_q, err_d;
   logic        nrd_q, nrd_d;
   logic        nwr_q, nwr_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] address_q, address_d;
   logic [31:0] wdata_q, wdata_d;

   logic        win;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [32:0] end_addr;
   logic        legal;

   // End address is formed in 33 bits so addresses near 2^32 cannot wrap into range.
   always_comb begin
      if (Req0 && Req1) win = FIXED_PRIO ? 1'b0 : ~last_grant_q;
      else              win = Req1;
      sel_we    = win ? We1    : We0;
      sel_addr  = win ? Addr1  : Addr0;
      sel_wdata = win ? WData1 : WData0;
      end_addr  = {1'b0, sel_addr} + 33'd3;
      legal     = (sel_addr[1:0] == 2'b00) && (end_addr <= LAST_BYTE);
   end

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      we_d         = we_q;
      last_grant_d = last_grant_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      err_d        = err_q;
      nrd_d        = nrd_q;
      nwr_d        = nwr_q;
      rdata_d      = rdata_q;
      address_d    = address_q;
      wdata_d      = wdata_q;
      case (state_q)
         IDLE: begin
            if (Req0 || Req1) begin
               gnt_d        = win;
               we_d         = sel_we;
               last_grant_d = win;
               if (legal) begin
                  state_d   = ACCESS;
                  address_d = sel_addr;
                  wdata_d   = sel_wdata;
                  nwr_d     = ~sel_we;
                  nrd_d     = sel_we;
               end else begin
                  state_d = RESP;
                  err_d   = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (!we_q) rdata_d = DataOut;
            nrd_d   = 1'b1;
            nwr_d   = 1'b1;
            err_d   = 1'b0;
            state_d = RESP;
         end
         RESP: begin
            ack0_d  = ~gnt_q;
            ack1_d  = gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= IDLE;
         gnt_q        <= 1'b0;
         we_q         <= 1'b0;
         last_grant_q <= 1'b1;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         err_q        <= 1'b0;
         nrd_q        <= 1'b1;
         nwr_q        <= 1'b1;
         rdata_q      <= '0;
         address_q    <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         we_q         <= we_d;
         last_grant_q <= last_grant_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         err_q        <= err_d;
         nrd_q        <= nrd_d;
         nwr_q        <= nwr_d;
         rdata_q      <= rdata_d;
         address_q    <= address_d;
         wdata_q      <= wdata_d;
      end
   end

   assign Ack0      = ack0_q;
   assign Ack1      = ack1_q;
   assign Err       = err_q;
   assign RData     = rdata_q;
   assign Address   = address_q;
   assign WriteData = wdata_q;
   assign nRD       = nrd_q;
   assign nWR       = nwr_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a byte-array reference memory and arbitration model
// predict every Ack (port, cycle, Err, RData); a monitor pops and compares as Acks appear.
module tb_ram_port_arbiter;
   localparam int MEM_BYTES = 61;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        Req0, Req1, We0, We1;
   logic [31:0] Addr0, Addr1, WData0, WData1;
   logic        Ack0, Ack1, Err, nRD, nWR;
   logic [31:0] RData, Address, WriteData, DataOut;

   logic        f_req0, f_req1, f_ack0, f_ack1, f_err, f_nrd, f_nwr;
   logic [31:0] f_rdata, f_address, f_wdata;

   always #5 CLK = ~CLK;

   ram_port_arbiter #(.MEM_BYTES(MEM_BYTES), .FIXED_PRIO(1'b0)) dut (
      .CLK(CLK), .nRST(nRST), .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
      .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
      .Ack0(Ack0), .Ack1(Ack1), .RData(RData), .Err(Err), .Address(Address),
      .WriteData(WriteData), .nRD(nRD), .nWR(nWR), .DataOut(DataOut));

   ram_port_arbiter #(.MEM_BYTES(MEM_BYTES), .FIXED_PRIO(1'b1)) dut_fix (
      .CLK(CLK), .nRST(nRST), .Req0(f_req0), .Req1(f_req1), .We0(1'b0), .We1(1'b0),
      .Addr0(32'd0), .Addr1(32'd4), .WData0(32'd0), .WData1(32'd0),
      .Ack0(f_ack0), .Ack1(f_ack1), .RData(f_rdata), .Err(f_err), .Address(f_address),
      .WriteData(f_wdata), .nRD(f_nrd), .nWR(f_nwr), .DataOut(32'h0));

   // RAM: big-endian bytes, write on negedge, combinational read
   logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};
   int         ram_a;
   logic       ram_ok;
   assign ram_a   = int'(Address[5:0]);
   assign ram_ok  = ({1'b0, Address} + 33'd3) < 33'(MEM_BYTES);
   assign DataOut = ram_ok ? {mem[ram_a], mem[ram_a+1], mem[ram_a+2], mem[ram_a+3]} : 32'h0;
   always @(negedge CLK)
      if (!nWR && ram_ok)
         for (int i = 0; i < 4; i++) mem[ram_a+i] <= WriteData[31-8*i -: 8];

   typedef struct {
      bit          port;
      bit          we;
      bit          err;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] ref_mem [MEM_BYTES] = '{default: 8'h00};
   bit         ref_last;
   logic [31:0] ref_rdata;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   function automatic bit is_legal(input logic [31:0] a);
      return (a % 4 == 0) && (longint'({32'h0, a}) + 3 <= longint'(MEM_BYTES - 1));
   endfunction

   // Reference: one transaction accepted at posedge k; returns the cycle its Ack appears.
   task automatic serve_port(input bit p, input int k, output int ack_cyc);
      exp_t        e;
      logic [31:0] a, wd;
      int          b;
      a  = p ? Addr1 : Addr0;
      wd = p ? WData1 : WData0;
      e.port = p; e.we = p ? We1 : We0; e.addr = a; e.wdata = wd;
      e.err  = !is_legal(a);
      if (!e.err) begin
         b = int'(a);
         if (e.we) for (int i = 0; i < 4; i++) ref_mem[b+i] = wd[31-8*i -: 8];
         else      ref_rdata = {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
      end
      e.rdata  = ref_rdata;
      e.cyc    = k + (e.err ? 1 : 2);
      ack_cyc  = e.cyc;
      ref_last = p;
      sb.push_back(e);
   endtask

   task automatic wait_done(input int n0, input int n1);
      int c0 = 0, c1 = 0;
      for (int n = 0; n < 40 && (Req0 || Req1); n++) begin
         @(posedge CLK); #1;
         if (Ack0) begin c0++; if (c0 >= n0) Req0 = 1'b0; end
         if (Ack1) begin c1++; if (c1 >= n1) Req1 = 1'b0; end
      end
      if (Req0 || Req1) begin
         fail("ack_timeout");
         Req0 = 1'b0; Req1 = 1'b0;
         sb.delete();
      end
   endtask

   task automatic run_batch(input bit r0, input bit r1, input bit w0, input bit w1,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1);
      int k, t;
      bit first;
      @(posedge CLK); #1;
      We0 = w0; Addr0 = a0; WData0 = d0; Req0 = r0;
      We1 = w1; Addr1 = a1; WData1 = d1; Req1 = r1;
      k = cyc + 1;
      if (r0 && r1) begin
         first = !ref_last;
         serve_port(first, k, t);
         serve_port(!first, t + 1, t);
      end else if (r0 || r1) begin
         serve_port(r1, k, t);
      end
      wait_done(1, 1);
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 9))
         0:       return 32'($urandom_range(0, 63));
         1:       return 32'hFFFF_FFFC;
         2:       return 32'd60;
         default: return 32'($urandom_range(0, 14) * 4);
      endcase
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge CLK); #1;
         if (nRST) begin
            chk("rd_wr_exclusive", 32'(!nRD && !nWR), 32'd0);
            if (!nRD || !nWR) begin
               if (sb.size() == 0) fail("access_without_txn");
               else begin
                  chk("access_legal", 32'(sb[0].err), 32'd0);
                  chk("access_addr", Address, sb[0].addr);
                  chk("access_is_write", 32'(!nWR), 32'(sb[0].we));
                  if (sb[0].we) chk("access_wdata", WriteData, sb[0].wdata);
               end
            end
            if (Ack0 || Ack1) begin
               if (sb.size() == 0) fail("ack_without_txn");
               else begin
                  e = sb.pop_front();
                  chk("ack_both", 32'(Ack0 && Ack1), 32'd0);
                  chk("ack_port", 32'(Ack1), 32'(e.port));
                  chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                  chk("ack_err", 32'(Err), 32'(e.err));
                  chk("ack_rdata", RData, e.rdata);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL global_timeout (t=%0t)", $time);
      $fatal(1, "bench did not finish");
   end

   initial begin : driver
      int k, t, n;
      bit order [2];
      logic [31:0] wd;
      Req0 = 0; Req1 = 0; We0 = 0; We1 = 0;
      Addr0 = 0; Addr1 = 0; WData0 = 0; WData1 = 0;
      f_req0 = 0; f_req1 = 0;
      ref_last = 1'b1; ref_rdata = '0;
      nRST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_ack0", 32'(Ack0), 32'd0);
      chk("rst_ack1", 32'(Ack1), 32'd0);
      chk("rst_err", 32'(Err), 32'd0);
      chk("rst_rdata", RData, 32'd0);
      chk("rst_address", Address, 32'd0);
      chk("rst_wdata", WriteData, 32'd0);
      chk("rst_nrd", 32'(nRD), 32'd1);
      chk("rst_nwr", 32'(nWR), 32'd1);
      nRST = 1'b1;

      // simultaneous reads, then a write/read of DEADBEEF
      run_batch(1, 1, 0, 0, 32'd0, 32'd4, 32'd0, 32'd0);
      run_batch(1, 1, 0, 0, 32'd8, 32'd12, 32'd0, 32'd0);
      run_batch(1, 0, 1, 0, 32'd8, 32'd0, 32'hDEAD_BEEF, 32'd0);
      run_batch(1, 0, 0, 0, 32'd8, 32'd0, 32'd0, 32'd0);
      chk("mem8", 32'(mem[8]), 32'hDE);
      chk("mem9", 32'(mem[9]), 32'hAD);
      chk("mem10", 32'(mem[10]), 32'hBE);
      chk("mem11", 32'(mem[11]), 32'hEF);

      // misaligned write and range boundaries
      run_batch(0, 1, 0, 1, 32'd0, 32'd6, 32'd0, 32'h1234_5678);
      run_batch(1, 0, 0, 0, 32'd56, 32'd0, 32'd0, 32'd0);
      run_batch(1, 0, 0, 0, 32'd60, 32'd0, 32'd0, 32'd0);
      run_batch(1, 0, 0, 0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd0);

      // Req0 held across four Acks
      @(posedge CLK); #1;
      We0 = 1'b0; Addr0 = 32'd8; Req0 = 1'b1;
      k = cyc + 1;
      for (int i = 0; i < 4; i++) begin serve_port(0, k, t); k = t + 1; end
      wait_done(4, 1);

      // FIXED_PRIO instance: port 0 always first on a tie
      for (int r = 0; r < 2; r++) begin
         @(posedge CLK); #1;
         f_req0 = 1'b1; f_req1 = 1'b1; n = 0;
         for (int c = 0; c < 20 && n < 2; c++) begin
            @(posedge CLK); #1;
            if (f_ack0 || f_ack1) begin
               chk("fix_ack_both", 32'(f_ack0 && f_ack1), 32'd0);
               chk("fix_err", 32'(f_err), 32'd0);
               order[n] = f_ack1; n++;
               if (f_ack0) f_req0 = 1'b0;
               if (f_ack1) f_req1 = 1'b0;
            end
         end
         if (n < 2) begin fail("fix_timeout"); f_req0 = 0; f_req1 = 0; end
         else begin
            chk("fix_first_port", 32'(order[0]), 32'd0);
            chk("fix_second_port", 32'(order[1]), 32'd1);
         end
      end

      // reset during the ACCESS cycle of a write
      @(posedge CLK); #1;
      wd = $urandom;
      We0 = 1'b1; Addr0 = 32'd16; WData0 = wd; Req0 = 1'b1;
      k = cyc + 1;
      sb.push_back('{port: 1'b0, we: 1'b1, err: 1'b0, addr: 32'd16, wdata: wd,
                     rdata: ref_rdata, cyc: k + 2});
      @(posedge CLK); #1;
      chk("rst6_nwr_low", 32'(nWR), 32'd0);
      #1 nRST = 1'b0;
      #1;
      sb.delete();
      ref_last = 1'b1; ref_rdata = '0;
      chk("rst6_nwr", 32'(nWR), 32'd1);
      chk("rst6_nrd", 32'(nRD), 32'd1);
      chk("rst6_address", Address, 32'd0);
      chk("rst6_wdata", WriteData, 32'd0);
      @(posedge CLK); #1;
      chk("rst6_no_ack", 32'(Ack0), 32'd0);
      nRST = 1'b1;
      k = cyc + 1;
      serve_port(0, k, t);
      wait_done(1, 1);

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         int r;
         r = $urandom_range(1, 3);
         run_batch(r[0], r[1], 1'($urandom), 1'($urandom), pick_addr(), pick_addr(),
                   $urandom, $urandom);
         repeat ($urandom_range(0, 2)) @(posedge CLK);
      end

      repeat (4) @(posedge CLK);
      #1;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      for (int i = 0; i < MEM_BYTES; i++) chk("ram_byte", 32'(mem[i]), 32'(ref_mem[i]));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
